output_arbiter: RTL

- Round-robin arbiter for one switch output port. Sits directly upstream of the output data mux.
- Receives per-input requests that are already destination-decoded for this output, and selects one winner.
- Drives the mux select and active-gate signals, plus a one-hot grant back to the input buffers.
- Holds a grant while the owner keeps requesting, up to a hold limit, so multi-word packets are not interleaved.

---
 rtl/output_arbiter_pkg.sv | 9 +
 rtl/output_arbiter_if.sv | 14 +
 rtl/output_arbiter_picker.sv | 30 +++
 rtl/output_arbiter.sv | 105 ++++++++++
 4 files changed

// File: rtl/output_arbiter_pkg.sv
// Shared types and constants for the output-port round-robin arbiter.
package output_arbiter_pkg;
  localparam int ADDR_WIDTH       = 4;
  localparam int PORT_IDX_W       = $clog2(ADDR_WIDTH);
  localparam int DEFAULT_MAX_HOLD = 4;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  typedef logic [PORT_IDX_W-1:0] port_idx_t;
endpackage

// File: rtl/output_arbiter_if.sv
// Request/grant bundle between the input buffers and one output-port arbiter.
interface output_arbiter_if
  import output_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = ADDR_WIDTH
);
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] gnt;
  port_idx_t            mux_sel;
  logic                 arb_active;

  modport master (input req, output gnt, mux_sel, arb_active);
  modport slave  (output req, input gnt, mux_sel, arb_active);
endinterface

// File: rtl/output_arbiter_picker.sv
// Combinational round-robin pick: first set req bit at ptr, ptr+1, ... mod NUM_PORTS.
module rr_picker #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);
  localparam logic [IDX_W:0] NP = NUM_PORTS[IDX_W:0];

  logic [2*NUM_PORTS-1:0] dbl;
  logic [NUM_PORTS-1:0]   rot;
  logic [IDX_W-1:0]       off;
  logic [IDX_W:0]         sum;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NUM_PORTS-1:0];
    off = '0;
    for (int i = NUM_PORTS-1; i >= 0; i--)
      if (rot[i]) off = IDX_W'(i);
    sum = {1'b0, off} + {1'b0, ptr};
    if (sum >= NP) sum = sum - NP;
    idx   = sum[IDX_W-1:0];
    found = |req;
  end
endmodule

// File: rtl/output_arbiter.sv
// Round-robin arbiter for one switch output port with grant hold.
// ARB_HOLD_LIMIT_EN: when defined, an owner is released after MAX_HOLD consecutive cycles.
module output_arbiter
  import output_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = ADDR_WIDTH,
  parameter int MAX_HOLD  = DEFAULT_MAX_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  output_arbiter_if.master bus
);
  if (MAX_HOLD < 1 || MAX_HOLD > 255 || NUM_PORTS < 2 || NUM_PORTS > (1 << PORT_IDX_W)) begin : g_bad_cfg
    $error("output_arbiter: illegal NUM_PORTS/MAX_HOLD");
  end

  arb_state_t           state, state_n;
  logic [NUM_PORTS-1:0] gnt, gnt_n;
  port_idx_t            sel, sel_n, rr_ptr, ptr_n, nxt_ptr, pick_ptr, pick_idx;
  logic                 act, act_n, keep, pick_found;
`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0]           hold_cnt, hold_n;
`endif

  assign bus.gnt        = gnt;
  assign bus.mux_sel    = sel;
  assign bus.arb_active = act;

  // While granting, the search for the next owner starts just past the current one.
  always_comb begin
    nxt_ptr  = (sel == port_idx_t'(NUM_PORTS-1)) ? '0 : sel + 1'b1;
    pick_ptr = (state == ARB_GRANT) ? nxt_ptr : rr_ptr;
  end

  rr_picker #(.NUM_PORTS(NUM_PORTS), .IDX_W(PORT_IDX_W)) u_pick (
    .req   (bus.req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_HOLD_LIMIT_EN
  assign keep = bus.req[sel] && (hold_cnt < 8'(MAX_HOLD));
`else
  assign keep = bus.req[sel];
`endif

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    sel_n   = sel;
    act_n   = act;
    ptr_n   = rr_ptr;
`ifdef ARB_HOLD_LIMIT_EN
    hold_n  = hold_cnt;
`endif
    if (state == ARB_GRANT && keep) begin
`ifdef ARB_HOLD_LIMIT_EN
      hold_n = hold_cnt + 8'd1;
`endif
    end else begin
      if (state == ARB_GRANT) ptr_n = nxt_ptr;
      if (pick_found) begin
        state_n         = ARB_GRANT;
        gnt_n           = '0;
        gnt_n[pick_idx] = 1'b1;
        sel_n           = pick_idx;
        act_n           = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
        hold_n          = 8'd1;
`endif
      end else begin
        // mux_sel keeps the last owner; the mux is gated off by arb_active.
        state_n = ARB_IDLE;
        gnt_n   = '0;
        act_n   = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
        hold_n  = 8'd0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      gnt      <= '0;
      sel      <= '0;
      act      <= 1'b0;
      rr_ptr   <= '0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt <= 8'd0;
`endif
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      sel      <= sel_n;
      act      <= act_n;
      rr_ptr   <= ptr_n;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt <= hold_n;
`endif
    end
  end
endmodule
